// File: rtl/didactic_apb_initiator_if.sv
// Bus bundle for the OBI-to-APB initiator bridge: the OBI request/response
// channel from the system-control interconnect and the APB completer port.
interface didactic_apb_initiator_if #(
    parameter int unsigned ApbAddrWidth = 32'd12,
    parameter int unsigned ApbDataWidth = 32'd32,
    parameter int unsigned ObiAddrWidth = 32'd32
);
    logic                    obi_req_i;
    logic                    obi_gnt_o;
    logic [ObiAddrWidth-1:0] obi_addr_i;
    logic                    obi_we_i;
    logic [3:0]              obi_be_i;
    logic [ApbDataWidth-1:0] obi_wdata_i;
    logic                    obi_rvalid_o;
    logic                    obi_rready_i;
    logic [ApbDataWidth-1:0] obi_rdata_o;
    logic                    obi_err_o;

    logic [ApbAddrWidth-1:0] paddr_o;
    logic                    psel_o;
    logic                    penable_o;
    logic                    pwrite_o;
    logic [ApbDataWidth-1:0] pwdata_o;
    logic [3:0]              pstrb_o;
    logic [ApbDataWidth-1:0] prdata_i;
    logic                    pready_i;
    logic                    pslverr_i;

    logic                    busy_o;

    // Bridge side: accepts OBI requests, drives the APB completer.
    modport master (
        input  obi_req_i, obi_addr_i, obi_we_i, obi_be_i, obi_wdata_i, obi_rready_i,
        input  prdata_i, pready_i, pslverr_i,
        output obi_gnt_o, obi_rvalid_o, obi_rdata_o, obi_err_o,
        output paddr_o, psel_o, penable_o, pwrite_o, pwdata_o, pstrb_o,
        output busy_o
    );

    // Environment side: the OBI requester and the APB completer.
    modport slave (
        output obi_req_i, obi_addr_i, obi_we_i, obi_be_i, obi_wdata_i, obi_rready_i,
        output prdata_i, pready_i, pslverr_i,
        input  obi_gnt_o, obi_rvalid_o, obi_rdata_o, obi_err_o,
        input  paddr_o, psel_o, penable_o, pwrite_o, pwdata_o, pstrb_o,
        input  busy_o
    );
endinterface

// File: rtl/didactic_apb_initiator.sv
// OBI-to-APB initiator bridge. Each granted OBI request becomes one APB
// SETUP+ACCESS transfer; the result is returned as an OBI response. A
// bounded ACCESS-phase wait turns a hung completer into an error response.
// ApbDataWidth must be 32 (the strobe/byte-enable fields are fixed at 4 bits).
module didactic_apb_initiator #(
    parameter int unsigned ApbAddrWidth  = 32'd12,
    parameter int unsigned ApbDataWidth  = 32'd32,
    parameter int unsigned ObiAddrWidth  = 32'd32,
    parameter int unsigned TimeoutCycles = 32'd255
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    didactic_apb_initiator_if.master bus
);
    // Counter only has to reach TimeoutCycles-1 before the abort fires.
    localparam int unsigned     CntW     = (TimeoutCycles > 32'd1) ? $clog2(TimeoutCycles) : 32'd1;
    localparam logic [CntW-1:0] CntLimit = CntW'(TimeoutCycles - 32'd1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_ACCESS,
        S_RESP
    } state_e;

    state_e                  r_state;
    state_e                  w_state_nxt;
    logic                    w_gnt;
    logic                    w_timeout;
    logic                    w_access_done;

    logic [ApbAddrWidth-1:0] r_paddr;
    logic                    r_pwrite;
    logic [ApbDataWidth-1:0] r_pwdata;
    logic [3:0]              r_pstrb;
    logic                    r_psel;
    logic                    r_penable;
    logic                    r_rvalid;
    logic [ApbDataWidth-1:0] r_rdata;
    logic                    r_err;
    logic [CntW-1:0]         r_cnt;

    // Upper OBI address bits are deliberately dropped: no decode error.
    logic                    w_unused_addr;
    assign w_unused_addr = ^bus.obi_addr_i[ObiAddrWidth-1:ApbAddrWidth];

    // State register; reset abandons any transfer without a response.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Grant, timeout detection and next-state selection.
    always_comb begin
        w_state_nxt   = r_state;
        w_gnt         = 1'b0;
        w_timeout     = 1'b0;
        w_access_done = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_gnt = bus.obi_req_i;
                if (w_gnt) w_state_nxt = S_SETUP;
            end
            S_SETUP: begin
                w_state_nxt = S_ACCESS;
            end
            S_ACCESS: begin
                // pready has priority over a timeout in the same cycle.
                w_timeout     = (TimeoutCycles != 32'd0) && !bus.pready_i && (r_cnt == CntLimit);
                w_access_done = bus.pready_i || w_timeout;
                if (w_access_done) w_state_nxt = S_RESP;
            end
            S_RESP: begin
                w_gnt = bus.obi_req_i && bus.obi_rready_i;
                if (bus.obi_rready_i) w_state_nxt = w_gnt ? S_SETUP : S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Request capture, APB phase outputs, wait counter and response registers.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_paddr   <= '0;
            r_pwrite  <= 1'b0;
            r_pwdata  <= '0;
            r_pstrb   <= 4'h0;
            r_psel    <= 1'b0;
            r_penable <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rdata   <= '0;
            r_err     <= 1'b0;
            r_cnt     <= '0;
        end else begin
            if (w_gnt) begin
                r_paddr  <= bus.obi_addr_i[ApbAddrWidth-1:0];
                r_pwrite <= bus.obi_we_i;
                r_pwdata <= bus.obi_wdata_i;
                r_pstrb  <= bus.obi_we_i ? bus.obi_be_i : 4'h0;
            end
            r_psel    <= (w_state_nxt == S_SETUP) || (w_state_nxt == S_ACCESS);
            r_penable <= (w_state_nxt == S_ACCESS);
            r_rvalid  <= (w_state_nxt == S_RESP);
            if (r_state == S_SETUP) begin
                r_cnt <= '0;
            end else if ((r_state == S_ACCESS) && !bus.pready_i) begin
                r_cnt <= r_cnt + CntW'(1);
            end
            if (w_access_done) begin
                r_rdata <= (bus.pready_i && !r_pwrite) ? bus.prdata_i : '0;
                r_err   <= bus.pready_i ? bus.pslverr_i : 1'b1;
            end
        end
    end

    assign bus.obi_gnt_o    = w_gnt;
    assign bus.obi_rvalid_o = r_rvalid;
    assign bus.obi_rdata_o  = r_rdata;
    assign bus.obi_err_o    = r_err;
    assign bus.paddr_o      = r_paddr;
    assign bus.psel_o       = r_psel;
    assign bus.penable_o    = r_penable;
    assign bus.pwrite_o     = r_pwrite;
    assign bus.pwdata_o     = r_pwdata;
    assign bus.pstrb_o      = r_pstrb;
    assign bus.busy_o       = (r_state != S_IDLE);
endmodule

// File: tb/tb_didactic_apb_initiator.sv
// Scoreboard bench for the OBI-to-APB initiator bridge. A driver issues OBI
// requests, a completer model answers on APB with a chosen number of wait
// states, and a monitor compares every OBI response against the queue.
module tb_didactic_apb_initiator;
    localparam int T = 4;

    typedef struct {
        logic [11:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic [3:0]  strb;
        int          waits;
        logic [31:0] prdata;
        logic        slverr;
    } apb_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          t_rv;
    } resp_t;

    logic clk;
    logic rst_ni;
    int   cyc;
    int   n_cmp;
    int   n_bad;
    int   rready_hold;
    bit   rready_rand;
    bit   front_seen;
    bit   abort;

    apb_t  apb_q[$];
    resp_t exp_q[$];

    didactic_apb_initiator_if #(.ApbAddrWidth(12), .ApbDataWidth(32), .ObiAddrWidth(32)) bus ();

    didactic_apb_initiator #(
        .ApbAddrWidth (32'd12),
        .ApbDataWidth (32'd32),
        .ObiAddrWidth (32'd32),
        .TimeoutCycles(32'(T))
    ) dut (
        .clk_i (clk),
        .rst_ni(rst_ni),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d expected < 50000", cyc);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: event missing or unexpected (cycle %0d)", name, cyc);
    endtask

    // Issue one OBI request; returns the cycle number of the handshake.
    task automatic issue(input logic [31:0] addr, input logic we, input logic [3:0] be,
                         input logic [31:0] wdata, input int waits, input logic [31:0] prd,
                         input logic serr, output int hs);
        apb_t  a;
        resp_t r;
        int    n;
        hs = -1;
        n  = 0;
        bus.obi_req_i   = 1'b1;
        bus.obi_addr_i  = addr;
        bus.obi_we_i    = we;
        bus.obi_be_i    = be;
        bus.obi_wdata_i = wdata;
        #1;
        while (!bus.obi_gnt_o) begin
            @(negedge clk);
            #1;
            n++;
            if (n > 100) begin
                fail_now("grant_timeout");
                bus.obi_req_i = 1'b0;
                return;
            end
        end
        hs       = cyc;
        a.addr   = addr[11:0];
        a.we     = we;
        a.wdata  = wdata;
        a.strb   = we ? be : 4'h0;
        a.waits  = waits;
        a.prdata = prd;
        a.slverr = serr;
        apb_q.push_back(a);
        if (waits >= T) begin
            r.rdata = 32'h0;
            r.err   = 1'b1;
            r.t_rv  = hs + 2 + T;
        end else begin
            r.rdata = we ? 32'h0 : prd;
            r.err   = serr;
            r.t_rv  = hs + 3 + waits;
        end
        exp_q.push_back(r);
        @(negedge clk);
        bus.obi_req_i   = 1'b0;
        bus.obi_addr_i  = $urandom;
        bus.obi_we_i    = 1'($urandom_range(0, 1));
        bus.obi_be_i    = 4'($urandom_range(0, 15));
        bus.obi_wdata_i = $urandom;
    endtask

    task automatic wait_idle();
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !bus.busy_o) return;
        end
        fail_now("drain_timeout");
    endtask

    // APB completer model: checks the phase signals and answers after `waits` cycles.
    initial begin
        apb_t cur;
        int   acnt;
        bit   active;
        active = 0;
        acnt   = 0;
        cur    = '{default: 0};
        bus.pready_i  = 1'b0;
        bus.prdata_i  = 32'h0;
        bus.pslverr_i = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.psel_o && !bus.penable_o) begin
                if (apb_q.size() == 0) begin
                    fail_now("apb_unexpected_setup");
                    active = 0;
                end else begin
                    cur    = apb_q.pop_front();
                    active = 1;
                    acnt   = 0;
                    chk("setup_paddr", 32'(bus.paddr_o), 32'(cur.addr));
                    chk("setup_pwrite", 32'(bus.pwrite_o), 32'(cur.we));
                    chk("setup_pwdata", bus.pwdata_o, cur.wdata);
                    chk("setup_pstrb", 32'(bus.pstrb_o), 32'(cur.strb));
                end
                bus.pready_i  = 1'($urandom_range(0, 1));
                bus.prdata_i  = $urandom;
                bus.pslverr_i = 1'($urandom_range(0, 1));
            end else if (bus.psel_o && bus.penable_o) begin
                acnt++;
                if (active) begin
                    chk("access_paddr", 32'(bus.paddr_o), 32'(cur.addr));
                    chk("access_pwrite", 32'(bus.pwrite_o), 32'(cur.we));
                    chk("access_pwdata", bus.pwdata_o, cur.wdata);
                    chk("access_pstrb", 32'(bus.pstrb_o), 32'(cur.strb));
                end
                if (active && acnt == cur.waits + 1) begin
                    bus.pready_i  = 1'b1;
                    bus.prdata_i  = cur.prdata;
                    bus.pslverr_i = cur.slverr;
                end else begin
                    bus.pready_i  = 1'b0;
                    bus.prdata_i  = $urandom;
                    bus.pslverr_i = 1'($urandom_range(0, 1));
                end
            end else begin
                if (active && !abort)
                    chk("access_cycles", 32'(acnt), 32'((cur.waits >= T) ? T : cur.waits + 1));
                active = 0;
                abort  = 0;
                bus.pready_i  = 1'($urandom_range(0, 1));
                bus.prdata_i  = $urandom;
                bus.pslverr_i = 1'($urandom_range(0, 1));
            end
        end
    end

    // Response monitor: pops the scoreboard when a response is accepted.
    initial begin
        bus.obi_rready_i = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.obi_rvalid_o) begin
                if (rready_hold > 0) begin
                    bus.obi_rready_i = 1'b0;
                    rready_hold--;
                end else begin
                    bus.obi_rready_i = rready_rand ? ($urandom_range(0, 2) != 0) : 1'b1;
                end
                if (exp_q.size() == 0) begin
                    fail_now("rsp_unexpected_rvalid");
                end else begin
                    if (!front_seen) begin
                        chk("rsp_latency", 32'(cyc), 32'(exp_q[0].t_rv));
                        front_seen = 1;
                    end
                    chk("rsp_rdata", bus.obi_rdata_o, exp_q[0].rdata);
                    chk("rsp_err", 32'(bus.obi_err_o), 32'(exp_q[0].err));
                    if (bus.obi_rready_i) begin
                        void'(exp_q.pop_front());
                        front_seen = 0;
                    end
                end
            end else begin
                bus.obi_rready_i = rready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            #1;
            if (bus.psel_o)
                chk("gnt_during_transfer", 32'(bus.obi_gnt_o), 32'h0);
            else if (bus.obi_rvalid_o && !bus.obi_rready_i)
                chk("gnt_resp_stalled", 32'(bus.obi_gnt_o), 32'h0);
            else if (bus.obi_rvalid_o && bus.obi_rready_i)
                chk("gnt_resp_accept", 32'(bus.obi_gnt_o), 32'(bus.obi_req_i));
        end
    end

    // Main stimulus sequence.
    initial begin
        int h0, h1, h2;
        cyc         = 0;
        n_cmp       = 0;
        n_bad       = 0;
        rready_hold = 0;
        rready_rand = 0;
        front_seen  = 0;
        abort       = 0;
        rst_ni      = 1'b0;
        bus.obi_req_i   = 1'b0;
        bus.obi_addr_i  = 32'h0;
        bus.obi_we_i    = 1'b0;
        bus.obi_be_i    = 4'h0;
        bus.obi_wdata_i = 32'h0;

        repeat (3) @(negedge clk);
        chk("rst_paddr", 32'(bus.paddr_o), 32'h0);
        chk("rst_pwdata", bus.pwdata_o, 32'h0);
        chk("rst_pstrb", 32'(bus.pstrb_o), 32'h0);
        chk("rst_pwrite", 32'(bus.pwrite_o), 32'h0);
        chk("rst_psel", 32'(bus.psel_o), 32'h0);
        chk("rst_penable", 32'(bus.penable_o), 32'h0);
        chk("rst_rvalid", 32'(bus.obi_rvalid_o), 32'h0);
        chk("rst_rdata", bus.obi_rdata_o, 32'h0);
        chk("rst_err", 32'(bus.obi_err_o), 32'h0);
        chk("rst_busy", 32'(bus.busy_o), 32'h0);
        rst_ni = 1'b1;
        @(negedge clk);

        // Zero-wait write.
        issue(32'h0000_0A04, 1'b1, 4'b0011, 32'hCAFE_F00D, 0, 32'h0, 1'b0, h0);
        wait_idle();
        // Read with 3 wait states.
        issue(32'h0000_0B10, 1'b0, 4'hF, 32'h5555_AAAA, 3, 32'h1234_5678, 1'b0, h0);
        wait_idle();
        // Read with completer error, response held for 5 cycles.
        rready_hold = 5;
        issue(32'h0000_0C20, 1'b0, 4'hF, 32'h0, 0, 32'hDEAD_BEEF, 1'b1, h0);
        wait_idle();
        // Hung completer: timeout; then pready on the last allowed ACCESS cycle.
        issue(32'h0000_0D30, 1'b0, 4'hF, 32'h0, 20, 32'h7777_1111, 1'b0, h0);
        wait_idle();
        issue(32'h0000_0D34, 1'b0, 4'hF, 32'h0, T - 1, 32'h8888_2222, 1'b0, h0);
        wait_idle();

        // Back-to-back reads with rready tied high.
        issue(32'h0000_0100, 1'b0, 4'hF, 32'h0, 0, 32'h0000_0001, 1'b0, h0);
        issue(32'h0000_0104, 1'b0, 4'hF, 32'h0, 0, 32'h0000_0002, 1'b0, h1);
        issue(32'h0000_0108, 1'b0, 4'hF, 32'h0, 0, 32'h0000_0003, 1'b0, h2);
        chk("b2b_gnt_gap1", 32'(h1 - h0), 32'd3);
        chk("b2b_gnt_gap2", 32'(h2 - h1), 32'd3);
        wait_idle();

        // Reset during ACCESS: transfer dropped, no response.
        issue(32'h0000_0E40, 1'b0, 4'hF, 32'h0, 6, 32'h3333_4444, 1'b0, h0);
        @(negedge clk);
        chk("pre_rst_access", 32'({bus.psel_o, bus.penable_o}), 32'h3);
        rst_ni = 1'b0;
        exp_q.delete();
        abort = 1;
        @(negedge clk);
        chk("midrst_psel", 32'(bus.psel_o), 32'h0);
        chk("midrst_penable", 32'(bus.penable_o), 32'h0);
        chk("midrst_rvalid", 32'(bus.obi_rvalid_o), 32'h0);
        chk("midrst_busy", 32'(bus.busy_o), 32'h0);
        rst_ni = 1'b1;
        repeat (3) @(negedge clk);
        issue(32'h0000_0F50, 1'b0, 4'hF, 32'h0, 1, 32'hA5A5_5A5A, 1'b0, h0);
        wait_idle();

        // Randomized traffic with random response back-pressure.
        rready_rand = 1;
        for (int i = 0; i < 40; i++) begin
            issue($urandom, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom,
                  int'($urandom_range(0, 6)), $urandom, 1'($urandom_range(0, 3) == 0), h0);
            if ($urandom_range(0, 2) == 0) wait_idle();
            else repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        wait_idle();
        rready_rand = 0;
        repeat (3) @(negedge clk);
        if (exp_q.size() != 0) fail_now("scoreboard_not_empty");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
